dm_adr_find: RTL and testbench

DM_ADR_FIND -- requirements
Module: dm_adr_find

---
 rtl/dm_adr_find_if.sv | 36 +++
 rtl/dm_adr_find.sv | 110 +++++++++++
 tb/tb_dm_adr_find.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dm_adr_find_if.sv
// -----------------------------------------------------------------------------
// dm_adr_find_if
// Bus bundle for the pointer-table reverse lookup block.
//   wr_en/wr_ptr/wr_adr        : table write port (one entry per strobe)
//   req_valid/req_ready/req_adr: lookup request handshake
//   rsp_valid/rsp_ready        : lookup response handshake
//   rsp_hit/rsp_ptr            : lookup result (lowest matching index, 0 on miss)
// master = requester / table writer, slave = dm_adr_find.
// -----------------------------------------------------------------------------
interface dm_adr_find_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 8
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic          wr_en;
  logic [PW-1:0] wr_ptr;
  logic [AW-1:0] wr_adr;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_adr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_hit;
  logic [PW-1:0] rsp_ptr;

  modport master (
    output wr_en, wr_ptr, wr_adr, req_valid, req_adr, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_ptr
  );

  modport slave (
    input  wr_en, wr_ptr, wr_adr, req_valid, req_adr, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_ptr
  );
endinterface

// File: rtl/dm_adr_find.sv
// -----------------------------------------------------------------------------
// dm_adr_find
// Holds a DEPTH x AW table mapping pointer index -> data-memory address and
// answers the inverse question: which (lowest) pointer yields a given address.
// The table is scanned one entry per cycle in ascending order, terminating on
// the first match.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset (FSM to IDLE, table to defaults)
//   bus   : dm_adr_find_if.slave (write port, request and response handshakes)
// -----------------------------------------------------------------------------
module dm_adr_find #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 8
) (
  input logic          clk,
  input logic          rst_n,
  dm_adr_find_if.slave bus
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t        state;
  logic [AW-1:0] tbl [DEPTH];
  logic [AW-1:0] key;
  logic [PW-1:0] idx;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_hit_q;
  logic [PW-1:0] rsp_ptr_q;
  logic          match;

  // Table write port: active in every state. Because the write is registered,
  // a compare of the same entry in the same cycle sees the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= (i < 5) ? AW'(i + 1) : '0;
      end
    end else if (bus.wr_en) begin
      tbl[bus.wr_ptr] <= bus.wr_adr;
    end
  end

  always_comb begin
    match = 1'b0;
    match = (tbl[idx] == key);
  end

  // Handshake outputs are registered alongside the state so req_ready is high
  // exactly in IDLE and rsp_valid exactly in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key         <= '0;
      idx         <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_ptr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            key         <= bus.req_adr;
            idx         <= '0;
            req_ready_q <= 1'b0;
            state       <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            rsp_hit_q   <= 1'b1;
            rsp_ptr_q   <= idx;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else if (idx == LAST) begin
            rsp_hit_q   <= 1'b0;
            rsp_ptr_q   <= '0;
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + PW'(1);
          end
        end
        DONE: begin
          // Returning to IDLE here (not accepting directly) forbids a
          // back-to-back request on the handshake edge.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_ptr   = rsp_ptr_q;
endmodule

// File: tb/tb_dm_adr_find.sv
// -----------------------------------------------------------------------------
// tb_dm_adr_find
// Directed bench for dm_adr_find (DEPTH=8, AW=8). Expected values are the
// hand-derived table contents, hit indices and scan latencies.
// -----------------------------------------------------------------------------
module tb_dm_adr_find;
  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  int   failed;

  dm_adr_find_if #(.DEPTH(8), .AW(8)) bus ();

  dm_adr_find #(.DEPTH(8), .AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ptr, input logic [7:0] adr);
    bus.wr_en  = 1'b1;
    bus.wr_ptr = ptr;
    bus.wr_adr = adr;
    tick();
    bus.wr_en  = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [7:0] adr);
    bus.req_valid = 1'b1;
    bus.req_adr   = adr;
    chk({tag, "_rdy_pre"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_adr   = ~adr;  // must not disturb the in-flight lookup
    chk({tag, "_rdy_busy"}, 32'(bus.req_ready), 32'd0);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_vld_after"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rdy_after"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic lookup(input string tag, input logic [7:0] adr, input logic hit,
                        input logic [2:0] ptr, input int lat);
    int n;
    accept(tag, adr);
    wait_rsp(n);
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_hit"}, 32'(bus.rsp_hit), 32'(hit));
    chk({tag, "_ptr"}, 32'(bus.rsp_ptr), 32'(ptr));
    finish_rsp(tag);
  endtask

  initial begin
    int n;
    logic seen;
    total = 0; passed = 0; failed = 0;
    bus.wr_en = 1'b0; bus.wr_ptr = '0; bus.wr_adr = '0;
    bus.req_valid = 1'b0; bus.req_adr = '0; bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_rdy", 32'(bus.req_ready), 32'd1);
    chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
    chk("rst_hit", 32'(bus.rsp_hit), 32'd0);
    chk("rst_ptr", 32'(bus.rsp_ptr), 32'd0);

    // Defaults: 1,2,3,4,5,0,0,0
    lookup("lk3", 8'd3, 1'b1, 3'd2, 3);
    lookup("lk9", 8'd9, 1'b0, 3'd0, 8);
    lookup("lk0", 8'd0, 1'b1, 3'd5, 6);

    wr(3'd6, 8'd64);
    lookup("lk64", 8'd64, 1'b1, 3'd6, 7);
    wr(3'd0, 8'd5);
    lookup("lk5", 8'd5, 1'b1, 3'd0, 1);  // entry4 also 5; lowest wins
    // Table: 5,2,3,4,5,0,64,0

    // Hold response with rsp_ready low while a new request is pending.
    accept("hold", 8'd4);
    wait_rsp(n);
    chk("hold_lat", 32'(n), 32'd4);
    bus.req_valid = 1'b1;
    bus.req_adr   = 8'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_vld", 32'(bus.rsp_valid), 32'd1);
      chk("hold_hit", 32'(bus.rsp_hit), 32'd1);
      chk("hold_ptr", 32'(bus.rsp_ptr), 32'd3);
      chk("hold_rdy", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("hs_vld", 32'(bus.rsp_valid), 32'd0);
    chk("hs_rdy_no_bypass", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("pend_accepted", 32'(bus.req_ready), 32'd0);
    wait_rsp(n);
    chk("pend_lat", 32'(n), 32'd2);
    chk("pend_ptr", 32'(bus.rsp_ptr), 32'd1);
    finish_rsp("pend");

    // Write entry2 on the edge that compares entry2: pre-write value used.
    accept("pw", 8'd3);
    tick();
    tick();
    bus.wr_en = 1'b1; bus.wr_ptr = 3'd2; bus.wr_adr = 8'd7;
    tick();
    bus.wr_en = 1'b0;
    chk("pw_vld", 32'(bus.rsp_valid), 32'd1);
    chk("pw_hit", 32'(bus.rsp_hit), 32'd1);
    chk("pw_ptr", 32'(bus.rsp_ptr), 32'd2);
    finish_rsp("pw");
    lookup("pw_miss3", 8'd3, 1'b0, 3'd0, 8);
    lookup("pw_lk7", 8'd7, 1'b1, 3'd2, 3);
    // Table: 5,2,7,4,5,0,64,0

    // Write to an already-scanned entry does not alter the in-flight result.
    accept("scn", 8'd64);
    repeat (3) tick();
    bus.wr_en = 1'b1; bus.wr_ptr = 3'd1; bus.wr_adr = 8'd64;
    tick();
    bus.wr_en = 1'b0;
    wait_rsp(n);
    chk("scn_lat", 32'(n), 32'd3);
    chk("scn_hit", 32'(bus.rsp_hit), 32'd1);
    chk("scn_ptr", 32'(bus.rsp_ptr), 32'd6);
    finish_rsp("scn");
    lookup("scn_new", 8'd64, 1'b1, 3'd1, 2);

    // Reset in the middle of a scan.
    accept("rsm", 8'd5);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rsm_vld_low", 32'(bus.rsp_valid), 32'd0);
    chk("rsm_rdy_low", 32'(bus.req_ready), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rsm_no_rsp", 32'(seen), 32'd0);
    chk("rsm_rdy", 32'(bus.req_ready), 32'd1);
    chk("rsm_hit", 32'(bus.rsp_hit), 32'd0);
    chk("rsm_ptr", 32'(bus.rsp_ptr), 32'd0);

    // Table back to defaults 1,2,3,4,5,0,0,0
    lookup("def1", 8'd1, 1'b1, 3'd0, 1);
    lookup("def2", 8'd2, 1'b1, 3'd1, 2);
    lookup("def3", 8'd3, 1'b1, 3'd2, 3);
    lookup("def4", 8'd4, 1'b1, 3'd3, 4);
    lookup("def5", 8'd5, 1'b1, 3'd4, 5);
    lookup("def0", 8'd0, 1'b1, 3'd5, 6);
    lookup("def64", 8'd64, 1'b0, 3'd0, 8);
    lookup("def7", 8'd7, 1'b0, 3'd0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
